// File: rtl/alu_disp_pkg.sv
// Shared types and helpers for the ALU function-class dispatcher.
// Holds the FSM state encoding and the per-unit latency lookup.
package alu_disp_pkg;

  localparam int unsigned LAT_VEC_MAX = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Latency field lookup; a zero field or an out-of-range index both run for one cycle.
  function automatic logic [31:0] lat_of(
    input logic [LAT_VEC_MAX-1:0] lat_vec,
    input int unsigned            idx,
    input int unsigned            num_units,
    input int unsigned            lat_w
  );
    logic [LAT_VEC_MAX-1:0] shifted;
    logic [31:0]            mask;
    logic [31:0]            val;
    shifted = lat_vec >> (idx * lat_w);
    mask    = (32'd1 << lat_w) - 32'd1;
    val     = shifted[31:0] & mask;
    if ((idx >= num_units) || (val == 32'd0)) begin
      val = 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/alu_onehot_dec.sv
// Binary to one-hot decoder for the ALU unit enables.
// Codes at or above NUM_UNITS decode to all zeros.
module alu_onehot_dec #(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic [SEL_W-1:0]     i_sel,
  output logic [NUM_UNITS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_unit_dispatcher.sv
// Registered dispatcher: decodes ALU_FUN into a one-hot unit enable, holds it
// for the unit's execution latency, then pulses OUT_VALID for one cycle.
module alu_unit_dispatcher
  import alu_disp_pkg::*;
#(
  parameter int unsigned                 SEL_W     = 2,
  parameter int unsigned                 NUM_UNITS = 4,
  parameter int unsigned                 LAT_W     = 4,
  parameter logic [NUM_UNITS*LAT_W-1:0]  UNIT_LAT  = {NUM_UNITS{LAT_W'(1)}}
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Enable,
  input  logic [SEL_W-1:0]     ALU_FUN,
  output logic [NUM_UNITS-1:0] Unit_Enable,
  output logic [SEL_W-1:0]     Unit_Sel,
  output logic                 Busy,
  output logic                 OUT_VALID,
  output logic                 Illegal
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [LAT_W-1:0]     r_cnt;
  logic [LAT_W-1:0]     w_cnt_nxt;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     w_sel_nxt;
  logic [NUM_UNITS-1:0] r_uen;
  logic [NUM_UNITS-1:0] w_uen_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_illegal;
  logic                 w_illegal_nxt;
  logic                 r_ill_pend;
  logic                 w_ill_pend_nxt;

  logic [NUM_UNITS-1:0] w_onehot;
  logic                 w_req_illegal;
  logic [LAT_W-1:0]     w_req_lat;

  alu_onehot_dec #(
    .SEL_W     (SEL_W),
    .NUM_UNITS (NUM_UNITS)
  ) u_dec (
    .i_sel    (ALU_FUN),
    .o_onehot (w_onehot)
  );

  assign w_req_illegal = (32'(ALU_FUN) >= NUM_UNITS);
  assign w_req_lat     = LAT_W'(lat_of(LAT_VEC_MAX'(UNIT_LAT), 32'(ALU_FUN), NUM_UNITS, LAT_W));

  // Next-state and next-output logic; every output is the registered copy of these.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sel_nxt      = r_sel;
    w_uen_nxt      = '0;
    w_busy_nxt     = 1'b0;
    w_valid_nxt    = 1'b0;
    w_illegal_nxt  = 1'b0;
    w_ill_pend_nxt = r_ill_pend;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Enable) begin
          w_state_nxt    = ST_EXEC;
          w_cnt_nxt      = w_req_lat;
          w_sel_nxt      = ALU_FUN;
          w_uen_nxt      = w_onehot;
          w_busy_nxt     = 1'b1;
          w_ill_pend_nxt = w_req_illegal;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_cnt_nxt = r_cnt - LAT_W'(1);
        if (r_cnt <= LAT_W'(1)) begin
          w_state_nxt   = ST_DONE;
          w_valid_nxt   = 1'b1;
          w_illegal_nxt = r_ill_pend;
        end else begin
          w_uen_nxt  = r_uen;
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_uen      <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
      r_ill_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_uen      <= w_uen_nxt;
      r_busy     <= w_busy_nxt;
      r_valid    <= w_valid_nxt;
      r_illegal  <= w_illegal_nxt;
      r_ill_pend <= w_ill_pend_nxt;
    end
  end

  assign Unit_Enable = r_uen;
  assign Unit_Sel    = r_sel;
  assign Busy        = r_busy;
  assign OUT_VALID   = r_valid;
  assign Illegal     = r_illegal;

endmodule

// File: tb/tb_alu_unit_dispatcher.sv
// Directed bench for alu_unit_dispatcher: latency trace, ignored requests,
// back-to-back, async reset abort and illegal codes on a 3-unit instance.
module tb_alu_unit_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       en1;
  logic [1:0] fun1;
  logic [3:0] uen1;
  logic [1:0] sel1;
  logic       busy1, valid1, ill1;
  logic       en2;
  logic [1:0] fun2;
  logic [2:0] uen2;
  logic [1:0] sel2;
  logic       busy2, valid2, ill2;

  int errors = 0;
  int checks = 0;

  // {Unit_Enable, Unit_Sel, Busy, OUT_VALID, Illegal}
  logic [8:0] obs1;
  logic [7:0] obs2;
  assign obs1 = {uen1, sel1, busy1, valid1, ill1};
  assign obs2 = {uen2, sel2, busy2, valid2, ill2};

  alu_unit_dispatcher #(
    .SEL_W(2), .NUM_UNITS(4), .LAT_W(4), .UNIT_LAT(16'h3210)
  ) dut (
    .CLK(clk), .RST(rst_n), .Enable(en1), .ALU_FUN(fun1),
    .Unit_Enable(uen1), .Unit_Sel(sel1), .Busy(busy1),
    .OUT_VALID(valid1), .Illegal(ill1)
  );

  alu_unit_dispatcher #(
    .SEL_W(2), .NUM_UNITS(3), .LAT_W(4), .UNIT_LAT(12'h321)
  ) dut3 (
    .CLK(clk), .RST(rst_n), .Enable(en2), .ALU_FUN(fun2),
    .Unit_Enable(uen2), .Unit_Sel(sel2), .Busy(busy2),
    .OUT_VALID(valid2), .Illegal(ill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en1 = 1'b0; fun1 = 2'd0; en2 = 1'b0; fun2 = 2'd0;
    #2;
    checks++;
    if (obs1 !== 9'b0) begin
      errors++; $display("FAIL reset_dut got=%b exp=%b", obs1, 9'b0);
    end
    checks++;
    if (obs2 !== 8'b0) begin
      errors++; $display("FAIL reset_dut3 got=%b exp=%b", obs2, 8'b0);
    end
    step();
    rst_n = 1'b1;
    step();
    // Unit 1, latency 1: EXEC then async reset mid-cycle
    en1 = 1'b1; fun1 = 2'd1;
    step();
    en1 = 1'b0;
    checks++;
    if (obs1 !== 9'b0010_01_100) begin
      errors++; $display("FAIL async_pre got=%b exp=%b", obs1, 9'b0010_01_100);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs1 !== 9'b0) begin
      errors++; $display("FAIL async_mid got=%b exp=%b", obs1, 9'b0);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (obs1 !== 9'b0) begin
      errors++; $display("FAIL async_idle got=%b exp=%b", obs1, 9'b0);
    end
  endtask

  task automatic test_latency2(input logic noise);
    en1 = 1'b1; fun1 = 2'd2;
    step();
    checks++;
    if (obs1 !== 9'b0100_10_100) begin
      errors++; $display("FAIL lat2_c1 noise=%0d got=%b exp=%b", noise, obs1, 9'b0100_10_100);
    end
    en1 = noise; fun1 = 2'd3;
    step();
    en1 = 1'b0;
    checks++;
    if (obs1 !== 9'b0100_10_100) begin
      errors++; $display("FAIL lat2_c2 noise=%0d got=%b exp=%b", noise, obs1, 9'b0100_10_100);
    end
    step();
    checks++;
    if (obs1 !== 9'b0000_10_010) begin
      errors++; $display("FAIL lat2_c3 noise=%0d got=%b exp=%b", noise, obs1, 9'b0000_10_010);
    end
    step();
    checks++;
    if (obs1 !== 9'b0000_10_000) begin
      errors++; $display("FAIL lat2_c4 noise=%0d got=%b exp=%b", noise, obs1, 9'b0000_10_000);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    en1 = 1'b1; fun1 = 2'd0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) en1 = 1'b0;
      step();
      exp = ((c % 2) == 1) ? 9'b0001_00_100 : 9'b0000_00_010;
      checks++;
      if (obs1 !== exp) begin
        errors++; $display("FAIL b2b_c%0d got=%b exp=%b", c, obs1, exp);
      end
      if (c == 5) en1 = 1'b0;
    end
    step();
    checks++;
    if (obs1 !== 9'b0000_00_000) begin
      errors++; $display("FAIL b2b_idle got=%b exp=%b", obs1, 9'b0000_00_000);
    end
  endtask

  task automatic test_reset_abort();
    en1 = 1'b1; fun1 = 2'd3;
    step();
    en1 = 1'b0;
    checks++;
    if (obs1 !== 9'b1000_11_100) begin
      errors++; $display("FAIL abort_c1 got=%b exp=%b", obs1, 9'b1000_11_100);
    end
    step();
    checks++;
    if (obs1 !== 9'b1000_11_100) begin
      errors++; $display("FAIL abort_c2 got=%b exp=%b", obs1, 9'b1000_11_100);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs1 !== 9'b0) begin
      errors++; $display("FAIL abort_rst got=%b exp=%b", obs1, 9'b0);
    end
    step();
    checks++;
    if (obs1 !== 9'b0) begin
      errors++; $display("FAIL abort_c3 got=%b exp=%b", obs1, 9'b0);
    end
    step();
    rst_n = 1'b1;
    for (int c = 5; c <= 9; c++) begin
      step();
      checks++;
      if (obs1 !== 9'b0) begin
        errors++; $display("FAIL abort_c%0d got=%b exp=%b", c, obs1, 9'b0);
      end
    end
  endtask

  task automatic test_illegal();
    en2 = 1'b1; fun2 = 2'd3;
    step();
    en2 = 1'b0;
    checks++;
    if (obs2 !== 8'b000_11_100) begin
      errors++; $display("FAIL ill_c1 got=%b exp=%b", obs2, 8'b000_11_100);
    end
    step();
    checks++;
    if (obs2 !== 8'b000_11_011) begin
      errors++; $display("FAIL ill_c2 got=%b exp=%b", obs2, 8'b000_11_011);
    end
    step();
    checks++;
    if (obs2 !== 8'b000_11_000) begin
      errors++; $display("FAIL ill_c3 got=%b exp=%b", obs2, 8'b000_11_000);
    end
    // Legal unit 1 on the 3-unit instance: latency 2, no Illegal
    en2 = 1'b1; fun2 = 2'd1;
    step();
    en2 = 1'b0;
    step();
    checks++;
    if (obs2 !== 8'b010_01_100) begin
      errors++; $display("FAIL leg3_c2 got=%b exp=%b", obs2, 8'b010_01_100);
    end
    step();
    checks++;
    if (obs2 !== 8'b000_01_010) begin
      errors++; $display("FAIL leg3_c3 got=%b exp=%b", obs2, 8'b000_01_010);
    end
  endtask

  initial begin
    test_reset();
    test_latency2(1'b0);
    test_latency2(1'b1);
    test_back_to_back();
    test_reset_abort();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
